sl_link_ctrl: RTL and testbench

Core-side controller for the SL transceiver's pair of 34-bit asynchronous FIFOs, sitting opposite the APB bridge. It pops command words from the APB→core FIFO and decodes the 2-bit modifier, then applies them to the core configuration, channel and transmit-data registers. It also arbitrates three core requesters (received data, status changes, configuration/channel echo) onto the single core→APB FIFO write port. FIFO words are `{modifier[1:0], payload[31:0]}`, with modifier codes CONFIG=0, DATA=1, STATUS=2, CHANNEL=3.

---
 rtl/sl_link_ctrl_if.sv | 38 +++
 rtl/sl_link_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sl_link_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sl_link_ctrl_if.sv
// Bundle of FIFO, transmit, receive and status signals between the SL link
// controller (master) and its surrounding FIFOs/core (slave).
interface sl_link_ctrl_if #(
    parameter int CONFIG_W  = 16,
    parameter int STATUS_W  = 16,
    parameter int CHANNEL_W = 2
);
    logic                 fifo_read_empty;
    logic [33:0]          fifo_read_data;
    logic                 fifo_read_inc;
    logic                 fifo_write_full;
    logic [33:0]          fifo_write_data;
    logic                 fifo_write_inc;
    logic [CONFIG_W-1:0]  config_r;
    logic [CHANNEL_W-1:0] channel_r;
    logic [31:0]          tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [31:0]          rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic [STATUS_W-1:0]  status_in;
    logic                 cmd_err;

    modport master (
        input  fifo_read_empty, fifo_read_data, fifo_write_full,
        input  tx_ready, rx_data, rx_valid, status_in,
        output fifo_read_inc, fifo_write_data, fifo_write_inc,
        output config_r, channel_r, tx_data, tx_valid, rx_ack, cmd_err
    );

    modport slave (
        output fifo_read_empty, fifo_read_data, fifo_write_full,
        output tx_ready, rx_data, rx_valid, status_in,
        input  fifo_read_inc, fifo_write_data, fifo_write_inc,
        input  config_r, channel_r, tx_data, tx_valid, rx_ack, cmd_err
    );
endinterface

// File: rtl/sl_link_ctrl.sv
// Core-side SL link controller: pops and decodes APB->core command words and
// arbitrates core requesters onto the core->APB FIFO write port.
module sl_link_ctrl #(
    parameter int CONFIG_W  = 16,
    parameter int STATUS_W  = 16,
    parameter int CHANNEL_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sl_link_ctrl_if.master bus
);
    localparam logic [1:0] MOD_CONFIG  = 2'd0;
    localparam logic [1:0] MOD_DATA    = 2'd1;
    localparam logic [1:0] MOD_STATUS  = 2'd2;
    localparam logic [1:0] MOD_CHANNEL = 2'd3;

    localparam logic [1:0] POP_IDLE    = 2'd0;
    localparam logic [1:0] POP_POP     = 2'd1;
    localparam logic [1:0] POP_SETTLE  = 2'd2;

    localparam logic [1:0] PSH_IDLE    = 2'd0;
    localparam logic [1:0] PSH_PUSH    = 2'd1;
    localparam logic [1:0] PSH_COOL    = 2'd2;

    logic [1:0]           r_pop_state;
    logic [33:0]          r_cmd;
    logic                 r_fifo_read_inc;
    logic [CONFIG_W-1:0]  r_config;
    logic [CHANNEL_W-1:0] r_channel;
    logic [31:0]          r_tx_data;
    logic                 r_tx_valid;
    logic                 r_cmd_err;
    logic                 r_cfg_echo_pend;
    logic                 r_ch_echo_pend;
    logic [1:0]           r_psh_state;
    logic                 r_fifo_write_inc;
    logic [33:0]          r_fifo_write_data;
    logic                 r_rx_ack;
    logic [STATUS_W-1:0]  r_last_status;

    logic        w_pop_start;
    logic [1:0]  w_cmd_mod;
    logic        w_in_pop;
    logic        w_req_st;
    logic        w_any_req;
    logic        w_push_go;
    logic        w_gnt_rx;
    logic        w_gnt_st;
    logic        w_gnt_cfg;
    logic        w_gnt_ch;
    logic [33:0] w_win_word;

    // A pending transmit word blocks every pop so command order is preserved.
    assign w_pop_start = (r_pop_state == POP_IDLE) && !bus.fifo_read_empty &&
                         (!r_tx_valid || bus.tx_ready);
    assign w_cmd_mod   = r_cmd[33:32];
    assign w_in_pop    = (r_pop_state == POP_POP);

    assign w_req_st  = (bus.status_in != r_last_status);
    assign w_any_req = bus.rx_valid || w_req_st || r_cfg_echo_pend || r_ch_echo_pend;
    // COOL also decides, so back-to-back pushes land two cycles apart.
    assign w_push_go = (r_psh_state != PSH_PUSH) && w_any_req && !bus.fifo_write_full;

    assign w_gnt_rx  = bus.rx_valid;
    assign w_gnt_st  = !bus.rx_valid && w_req_st;
    assign w_gnt_cfg = !bus.rx_valid && !w_req_st && r_cfg_echo_pend;
    assign w_gnt_ch  = !bus.rx_valid && !w_req_st && !r_cfg_echo_pend && r_ch_echo_pend;

    // Word presented by the highest-priority active requester.
    always_comb begin
        w_win_word = 34'b0;
        if (w_gnt_rx) begin
            w_win_word = {MOD_DATA, bus.rx_data};
        end else if (w_gnt_st) begin
            w_win_word = {MOD_STATUS, 32'(bus.status_in)};
        end else if (w_gnt_cfg) begin
            w_win_word = {MOD_CONFIG, 32'(r_config)};
        end else if (w_gnt_ch) begin
            w_win_word = {MOD_CHANNEL, 32'(r_channel)};
        end else begin
            w_win_word = 34'b0;
        end
    end

    // Pop FSM and command dispatch into the core registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_state     <= POP_IDLE;
            r_cmd           <= 34'b0;
            r_fifo_read_inc <= 1'b0;
            r_config        <= '0;
            r_channel       <= '0;
            r_tx_data       <= 32'b0;
            r_tx_valid      <= 1'b0;
            r_cmd_err       <= 1'b0;
        end else begin
            r_fifo_read_inc <= 1'b0;
            r_cmd_err       <= 1'b0;
            if (r_tx_valid && bus.tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            case (r_pop_state)
                POP_IDLE: begin
                    if (w_pop_start) begin
                        r_cmd           <= bus.fifo_read_data;
                        r_fifo_read_inc <= 1'b1;
                        r_pop_state     <= POP_POP;
                    end
                end
                POP_POP: begin
                    r_pop_state <= POP_SETTLE;
                    case (w_cmd_mod)
                        MOD_CONFIG:  r_config  <= r_cmd[CONFIG_W-1:0];
                        MOD_CHANNEL: r_channel <= r_cmd[CHANNEL_W-1:0];
                        MOD_DATA: begin
                            r_tx_data  <= r_cmd[31:0];
                            r_tx_valid <= 1'b1;
                        end
                        MOD_STATUS:  r_cmd_err <= 1'b1;
                        default:     r_cmd_err <= 1'b0;
                    endcase
                end
                POP_SETTLE: r_pop_state <= POP_IDLE;
                default:    r_pop_state <= POP_IDLE;
            endcase
        end
    end

    // Echo-pending flags; a new set beats a same-cycle clear so a fresh echo follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_echo_pend <= 1'b0;
            r_ch_echo_pend  <= 1'b0;
        end else begin
            if (w_in_pop && (w_cmd_mod == MOD_CONFIG)) begin
                r_cfg_echo_pend <= 1'b1;
            end else if (w_push_go && w_gnt_cfg) begin
                r_cfg_echo_pend <= 1'b0;
            end
            if (w_in_pop && (w_cmd_mod == MOD_CHANNEL)) begin
                r_ch_echo_pend <= 1'b1;
            end else if (w_push_go && w_gnt_ch) begin
                r_ch_echo_pend <= 1'b0;
            end
        end
    end

    // Push arbiter: payload and strobes are captured on entry to PUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psh_state       <= PSH_IDLE;
            r_fifo_write_inc  <= 1'b0;
            r_fifo_write_data <= 34'b0;
            r_rx_ack          <= 1'b0;
            r_last_status     <= '0;
        end else begin
            r_fifo_write_inc <= 1'b0;
            r_rx_ack         <= 1'b0;
            case (r_psh_state)
                PSH_IDLE, PSH_COOL: begin
                    if (w_push_go) begin
                        r_psh_state       <= PSH_PUSH;
                        r_fifo_write_inc  <= 1'b1;
                        r_fifo_write_data <= w_win_word;
                        r_rx_ack          <= w_gnt_rx;
                        if (w_gnt_st) begin
                            r_last_status <= bus.status_in;
                        end
                    end else begin
                        r_psh_state <= PSH_IDLE;
                    end
                end
                PSH_PUSH: r_psh_state <= PSH_COOL;
                default:  r_psh_state <= PSH_IDLE;
            endcase
        end
    end

    assign bus.fifo_read_inc   = r_fifo_read_inc;
    assign bus.fifo_write_inc  = r_fifo_write_inc;
    assign bus.fifo_write_data = r_fifo_write_data;
    assign bus.config_r        = r_config;
    assign bus.channel_r       = r_channel;
    assign bus.tx_data         = r_tx_data;
    assign bus.tx_valid        = r_tx_valid;
    assign bus.rx_ack          = r_rx_ack;
    assign bus.cmd_err         = r_cmd_err;
endmodule

// File: tb/tb_sl_link_ctrl.sv
// Directed bench for sl_link_ctrl: single-command vector table plus sequences
// for stalls, arbitration order, full back-pressure and mid-transfer reset.
module tb_sl_link_ctrl;
    logic clk;
    logic rst_n;

    sl_link_ctrl_if bus ();
    sl_link_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] word;
        logic [15:0] cfg;
        logic [1:0]  ch;
        logic [31:0] txd;
        logic        txv;
        int          nerr;
        int          npush;
        logic [33:0] push;
    } vec_t;

    vec_t        vecs [6];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [33:0] rdq [$];
    logic [33:0] push_w [$];
    int          push_c [$];
    logic        push_ack [$];
    logic        pop_seen, ack_seen, full_d, inc_d, rinc_d;
    int          err_cnt = 0, pop_cnt = 0, full_viol = 0, b2b_viol = 0;
    int          base, ebase, pbase, waited;

    // Observe the DUT at each edge: FIFO strobes, pushes and protocol rules.
    always @(posedge clk) begin
        pop_seen <= bus.fifo_read_inc;
        ack_seen <= bus.rx_ack;
        full_d   <= bus.fifo_write_full;
        inc_d    <= bus.fifo_write_inc;
        rinc_d   <= bus.fifo_read_inc;
        if (bus.cmd_err === 1'b1) err_cnt <= err_cnt + 1;
        if (bus.fifo_read_inc === 1'b1) begin
            pop_cnt <= pop_cnt + 1;
            if (rinc_d === 1'b1) b2b_viol <= b2b_viol + 1;
        end
        if (bus.fifo_write_inc === 1'b1) begin
            push_w.push_back(bus.fifo_write_data);
            push_c.push_back(cyc);
            push_ack.push_back(bus.rx_ack);
            if (full_d === 1'b1) full_viol <= full_viol + 1;
            if (inc_d === 1'b1) b2b_viol <= b2b_viol + 1;
        end
    end

    task automatic refresh();
        bus.fifo_read_empty = (rdq.size() == 0);
        bus.fifo_read_data  = (rdq.size() == 0) ? 34'b0 : rdq[0];
    endtask

    task automatic fifo_put(input logic [33:0] w);
        rdq.push_back(w);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pop_seen === 1'b1 && rdq.size() > 0) void'(rdq.pop_front());
        if (ack_seen === 1'b1) bus.rx_valid = 1'b0;
        refresh();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_read_inc"},  64'(bus.fifo_read_inc),   64'd0);
        chk({tag, "_write_inc"}, 64'(bus.fifo_write_inc),  64'd0);
        chk({tag, "_wdata"},     64'(bus.fifo_write_data), 64'd0);
        chk({tag, "_config"},    64'(bus.config_r),        64'd0);
        chk({tag, "_channel"},   64'(bus.channel_r),       64'd0);
        chk({tag, "_tx_data"},   64'(bus.tx_data),         64'd0);
        chk({tag, "_tx_valid"},  64'(bus.tx_valid),        64'd0);
        chk({tag, "_rx_ack"},    64'(bus.rx_ack),          64'd0);
        chk({tag, "_cmd_err"},   64'(bus.cmd_err),         64'd0);
    endtask

    initial begin
        vecs[0] = '{{2'd0, 32'h0000_1234}, 16'h1234, 2'd0, 32'h0,         1'b0, 0, 1, {2'd0, 32'h0000_1234}};
        vecs[1] = '{{2'd3, 32'h0000_0002}, 16'h1234, 2'd2, 32'h0,         1'b0, 0, 1, {2'd3, 32'h0000_0002}};
        vecs[2] = '{{2'd2, 32'h0000_FFFF}, 16'h1234, 2'd2, 32'h0,         1'b0, 1, 0, 34'b0};
        vecs[3] = '{{2'd1, 32'h1234_5678}, 16'h1234, 2'd2, 32'h1234_5678, 1'b1, 0, 0, 34'b0};
        vecs[4] = '{{2'd0, 32'hFFFF_0001}, 16'h0001, 2'd2, 32'h1234_5678, 1'b0, 0, 1, {2'd0, 32'h0000_0001}};
        vecs[5] = '{{2'd3, 32'hFFFF_FFFD}, 16'h0001, 2'd1, 32'h1234_5678, 1'b0, 0, 1, {2'd3, 32'h0000_0001}};

        rst_n = 1'b0;
        bus.fifo_write_full = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 32'h0;
        bus.status_in = 16'h0;
        refresh();
        ticks(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        ticks(2);

        // Config pop latency and its echo push.
        base = push_w.size();
        fifo_put({2'd0, 32'h0000_A5C3});
        tick();
        chk("a_read_inc_hi", 64'(bus.fifo_read_inc), 64'd1);
        tick();
        chk("a_read_inc_lo", 64'(bus.fifo_read_inc), 64'd0);
        chk("a_config",      64'(bus.config_r),      64'h0000_A5C3);
        tick();
        chk("a_write_inc",   64'(bus.fifo_write_inc),  64'd1);
        chk("a_write_data",  64'(bus.fifo_write_data), {30'd0, 2'd0, 32'h0000_A5C3});
        ticks(4);
        chk("a_push_count",  64'(push_w.size() - base), 64'd1);

        // Single-command vector table.
        for (int v = 0; v < 6; v++) begin
            base  = push_w.size();
            ebase = err_cnt;
            fifo_put(vecs[v].word);
            ticks(8);
            chk($sformatf("v%0d_config", v),   64'(bus.config_r),  64'(vecs[v].cfg));
            chk($sformatf("v%0d_channel", v),  64'(bus.channel_r), 64'(vecs[v].ch));
            chk($sformatf("v%0d_tx_data", v),  64'(bus.tx_data),   64'(vecs[v].txd));
            chk($sformatf("v%0d_tx_valid", v), 64'(bus.tx_valid),  64'(vecs[v].txv));
            chk($sformatf("v%0d_cmd_err", v),  64'(err_cnt - ebase), 64'(vecs[v].nerr));
            chk($sformatf("v%0d_npush", v),    64'(push_w.size() - base), 64'(vecs[v].npush));
            if (vecs[v].npush == 1 && push_w.size() > base)
                chk($sformatf("v%0d_push", v), 64'(push_w[base]), 64'(vecs[v].push));
            if (vecs[v].txv) begin
                bus.tx_ready = 1'b1;
                tick();
                bus.tx_ready = 1'b0;
                chk($sformatf("v%0d_tx_accept", v), 64'(bus.tx_valid), 64'd0);
            end
        end

        // Two DATA words; the second is held back while the first is unaccepted.
        pbase = pop_cnt;
        fifo_put({2'd1, 32'h1111_1111});
        fifo_put({2'd1, 32'h2222_2222});
        ticks(12);
        chk("b_tx_valid_held", 64'(bus.tx_valid), 64'd1);
        chk("b_tx_data_first", 64'(bus.tx_data),  64'h1111_1111);
        chk("b_one_pop",       64'(pop_cnt - pbase), 64'd1);
        chk("b_fifo_left",     64'(rdq.size()),   64'd1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("b_tx_valid_clr",  64'(bus.tx_valid),      64'd0);
        chk("b_second_pop",    64'(bus.fifo_read_inc), 64'd1);
        tick();
        chk("b_tx_data_second", 64'(bus.tx_data),  64'h2222_2222);
        chk("b_tx_valid_again", 64'(bus.tx_valid), 64'd1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        ticks(2);

        // Full back-pressure with rx, status and config echo all pending.
        bus.fifo_write_full = 1'b1;
        base = push_w.size();
        fifo_put({2'd0, 32'h0000_00C3});
        bus.rx_data   = 32'hDEAD_BEEF;
        bus.rx_valid  = 1'b1;
        bus.status_in = 16'h0004;
        ticks(20);
        chk("c_no_push_full", 64'(push_w.size() - base), 64'd0);
        chk("c_config",       64'(bus.config_r),         64'h0000_00C3);
        bus.fifo_write_full = 1'b0;
        tick();
        chk("c_resume_inc",   64'(bus.fifo_write_inc), 64'd1);
        chk("c_resume_ack",   64'(bus.rx_ack),         64'd1);
        ticks(8);
        chk("c_npush", 64'(push_w.size() - base), 64'd3);
        if (push_w.size() - base == 3) begin
            chk("c_push0_rx",     64'(push_w[base]),     {30'd0, 2'd1, 32'hDEAD_BEEF});
            chk("c_push1_status", 64'(push_w[base + 1]), {30'd0, 2'd2, 32'h0000_0004});
            chk("c_push2_cfg",    64'(push_w[base + 2]), {30'd0, 2'd0, 32'h0000_00C3});
            chk("c_ack0", 64'(push_ack[base]),     64'd1);
            chk("c_ack1", 64'(push_ack[base + 1]), 64'd0);
            chk("c_ack2", 64'(push_ack[base + 2]), 64'd0);
            chk("c_gap01", 64'(push_c[base + 1] - push_c[base]),     64'd2);
            chk("c_gap12", 64'(push_c[base + 2] - push_c[base + 1]), 64'd2);
        end

        // Reset while tx_valid is high and a status push is in flight.
        fifo_put({2'd1, 32'hCAFE_0001});
        ticks(2);
        chk("f_tx_valid_pre", 64'(bus.tx_valid), 64'd1);
        bus.status_in = 16'h0010;
        base = push_w.size();
        tick();
        chk("f_push_cycle", 64'(bus.fifo_write_inc), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("f_async");
        ticks(2);
        rst_n = 1'b1;
        chk("f_no_partial", 64'(push_w.size() - base), 64'd0);
        waited = 0;
        while (push_w.size() == base && waited < 10) begin
            tick();
            waited++;
        end
        chk("f_status_push_seen", 64'(push_w.size() - base), 64'd1);
        if (push_w.size() > base)
            chk("f_status_push", 64'(push_w[base]), {30'd0, 2'd2, 32'h0000_0010});
        chk("f_config_after", 64'(bus.config_r), 64'd0);
        ticks(4);

        chk("full_rule",     64'(full_viol), 64'd0);
        chk("single_pulses", 64'(b2b_viol),  64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
